// File: rtl/i3c_pkg.sv
// Shared types for the I3C/I2C bus resolver: per-line state encoding and a
// counter-width helper used by the line and top-level counters.
package i3c_pkg;

    typedef enum logic [1:0] {
        LINE_LOW    = 2'd0,
        LINE_RISING = 2'd1,
        LINE_HIGH   = 2'd2
    } bus_line_state_e;

    // Width needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/i3c_bus_line.sv
// One open-drain bus line: wired-AND resolution of all agent drives, pull-up
// rise-time model and same-cycle high/low drive conflict detection.
module i3c_bus_line
    import i3c_pkg::*;
#(
    parameter int NumAgents  = 2,
    parameter int RiseCycles = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumAgents-1:0] o_i,
    input  logic [NumAgents-1:0] en_i,
    output logic                 line_o,
    output logic                 conflict_o
);

    localparam int RcW = cnt_width(RiseCycles);
    localparam logic [RcW-1:0] RiseLast = (RiseCycles <= 0) ? '0 : RcW'(RiseCycles - 1);

    logic            drive_low_s;
    logic            drive_high_s;
    bus_line_state_e state_r;
    bus_line_state_e state_nxt_s;
    logic [RcW-1:0]  rise_cnt_r;
    logic [RcW-1:0]  rise_cnt_nxt_s;

    assign drive_low_s  = |(en_i & ~o_i);
    assign drive_high_s = |(en_i & o_i);

    // State and rise-counter registers; reset leaves the line pulled high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= LINE_HIGH;
            rise_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            rise_cnt_r <= rise_cnt_nxt_s;
        end
    end

    // Next-state logic: low dominates, push-pull high skips the rise delay.
    always_comb begin
        state_nxt_s    = state_r;
        rise_cnt_nxt_s = rise_cnt_r;
        if (drive_low_s) begin
            state_nxt_s    = LINE_LOW;
            rise_cnt_nxt_s = '0;
        end else if (drive_high_s) begin
            state_nxt_s = LINE_HIGH;
        end else begin
            case (state_r)
                LINE_LOW: begin
                    if (RiseCycles == 0) begin
                        state_nxt_s = LINE_HIGH;
                    end else begin
                        state_nxt_s    = LINE_RISING;
                        rise_cnt_nxt_s = '0;
                    end
                end
                LINE_RISING: begin
                    if (rise_cnt_r == RiseLast) begin
                        state_nxt_s = LINE_HIGH;
                    end else begin
                        rise_cnt_nxt_s = rise_cnt_r + RcW'(1);
                    end
                end
                LINE_HIGH: state_nxt_s = LINE_HIGH;
                default:   state_nxt_s = LINE_HIGH;
            endcase
        end
    end

    // Output decode: the line reads high only once fully risen.
    always_comb begin
        line_o     = (state_r == LINE_HIGH);
        conflict_o = drive_low_s & drive_high_s;
    end

endmodule

// File: rtl/i3c_bus_model.sv
// I3C/I2C bus resolver top: SCL/SDA line models, START/STOP and bus-free
// detection, conflict counter (enabled by I3C_BUS_MODEL_CONFLICT_CHECK_EN).
module i3c_bus_model
    import i3c_pkg::*;
#(
    parameter int NumAgents     = 2,
    parameter int RiseCycles    = 4,
    parameter int BusFreeCycles = 8,
    parameter int CntWidth      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumAgents-1:0] scl_o_i,
    input  logic [NumAgents-1:0] scl_en_i,
    input  logic [NumAgents-1:0] sda_o_i,
    input  logic [NumAgents-1:0] sda_en_i,
    input  logic                 clr_i,
    output logic                 scl_o,
    output logic                 sda_o,
    output logic                 start_o,
    output logic                 stop_o,
    output logic                 idle_o,
    output logic                 conflict_o,
    output logic [CntWidth-1:0]  conflict_cnt_o
);

    localparam int BfW = cnt_width(BusFreeCycles);
    localparam logic [BfW-1:0] BfMax = BfW'(BusFreeCycles);

    logic           scl_line_s;
    logic           sda_line_s;
    logic           scl_conflict_s;
    logic           sda_conflict_s;
    logic           scl_q_r;
    logic           sda_q_r;
    logic           start_r;
    logic           stop_r;
    logic           idle_r;
    logic           start_s;
    logic           stop_s;
    logic [BfW-1:0] bf_cnt_r;
    logic [BfW-1:0] bf_cnt_nxt_s;

    i3c_bus_line #(
        .NumAgents (NumAgents),
        .RiseCycles(RiseCycles)
    ) u_scl_line (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .o_i       (scl_o_i),
        .en_i      (scl_en_i),
        .line_o    (scl_line_s),
        .conflict_o(scl_conflict_s)
    );

    i3c_bus_line #(
        .NumAgents (NumAgents),
        .RiseCycles(RiseCycles)
    ) u_sda_line (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .o_i       (sda_o_i),
        .en_i      (sda_en_i),
        .line_o    (sda_line_s),
        .conflict_o(sda_conflict_s)
    );

    assign scl_o   = scl_line_s;
    assign sda_o   = sda_line_s;
    assign start_o = start_r;
    assign stop_o  = stop_r;
    assign idle_o  = idle_r;

    // SDA edges qualified by SCL high in both cycles; simultaneous edges are ignored.
    always_comb begin
        start_s = scl_q_r & scl_line_s & sda_q_r & ~sda_line_s;
        stop_s  = scl_q_r & scl_line_s & ~sda_q_r & sda_line_s;
        if (scl_line_s & sda_line_s) begin
            if (bf_cnt_r == BfMax) begin
                bf_cnt_nxt_s = bf_cnt_r;
            end else begin
                bf_cnt_nxt_s = bf_cnt_r + BfW'(1);
            end
        end else begin
            bf_cnt_nxt_s = '0;
        end
    end

    // Line history, START/STOP pulses and bus-free tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_q_r  <= 1'b1;
            sda_q_r  <= 1'b1;
            start_r  <= 1'b0;
            stop_r   <= 1'b0;
            bf_cnt_r <= '0;
            idle_r   <= 1'b0;
        end else begin
            scl_q_r  <= scl_line_s;
            sda_q_r  <= sda_line_s;
            start_r  <= start_s;
            stop_r   <= stop_s;
            bf_cnt_r <= bf_cnt_nxt_s;
            idle_r   <= (bf_cnt_nxt_s == BfMax);
        end
    end

`ifdef I3C_BUS_MODEL_CONFLICT_CHECK_EN
    logic                conflict_s;
    logic                conflict_r;
    logic [CntWidth-1:0] conflict_cnt_r;

    assign conflict_s = scl_conflict_s | sda_conflict_s;

    // Conflict pulse and saturating count; a clear in the same cycle wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_r     <= 1'b0;
            conflict_cnt_r <= '0;
        end else begin
            conflict_r <= conflict_s;
            if (clr_i) begin
                conflict_cnt_r <= '0;
            end else if (conflict_s && (conflict_cnt_r != {CntWidth{1'b1}})) begin
                conflict_cnt_r <= conflict_cnt_r + CntWidth'(1);
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    assign conflict_o     = conflict_r;
    assign conflict_cnt_o = conflict_cnt_r;
`else
    logic unused_conflict_s;

    assign unused_conflict_s = ^{clr_i, scl_conflict_s, sda_conflict_s};
    assign conflict_o        = 1'b0;
    assign conflict_cnt_o    = '0;
`endif

endmodule
